// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing logic.
package cpu_pkg;

  localparam int RAW = 5;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_EALU = 2'b01,
    FWD_MALU = 2'b10,
    FWD_MMEM = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide unit sequencer: launch pulse, then busy for MDU_LAT cycles.
module mdu_seq
  import cpu_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic clrn,
  input  logic launch,
  output logic mdu_start,
  output logic mdu_busy
);

  localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(MDU_LAT - 1);

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Busy covers counter values LOAD..0, i.e. exactly MDU_LAT cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_start = 1'b0;
    mdu_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          mdu_start = 1'b1;
          state_d   = BUSY;
          cnt_d     = LOAD;
        end
      end
      BUSY: begin
        mdu_busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: EXE/MEM destination scoreboard, forwarding selects,
// load-use / MDU stalls, branch flush and MDU sequencing.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int RAW     = cpu_pkg::RAW,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [RAW-1:0]   id_rs,
  input  logic [RAW-1:0]   id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RAW-1:0]   id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_mdu_op,
  input  logic             id_mdu_use,
  input  logic             id_br_taken,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             flush_if,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);
  import cpu_pkg::*;

  logic             e_wreg_q, e_wreg_d, e_m2reg_q, e_m2reg_d;
  logic             m_wreg_q, m_wreg_d, m_m2reg_q, m_m2reg_d;
  logic [RAW-1:0]   e_rn_q, e_rn_d, m_rn_q, m_rn_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [RAW-1:0] src [2];
  logic [1:0]     use_src;
  logic [1:0]     ld_hit;
  logic           luse, mstall, stall;

  assign src[0]     = id_rs;
  assign src[1]     = id_rt;
  assign use_src[0] = id_use_rs;
  assign use_src[1] = id_use_rt;

  // Register 0 is hard-wired zero, so an rn=0 entry never forwards or stalls.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic       e_hit, m_hit;
      logic [1:0] sel;
      assign e_hit      = e_wreg_q & ~e_m2reg_q & (e_rn_q != '0) & (e_rn_q == src[gi]);
      assign m_hit      = m_wreg_q & (m_rn_q != '0) & (m_rn_q == src[gi]);
      assign ld_hit[gi] = e_wreg_q & e_m2reg_q & (e_rn_q != '0) & use_src[gi]
                          & (e_rn_q == src[gi]);
      always_comb begin
        sel = FWD_RF;
        if (e_hit) begin
          sel = FWD_EALU;
        end else if (m_hit) begin
          sel = m_m2reg_q ? FWD_MMEM : FWD_MALU;
        end
      end
    end
  endgenerate

  assign fwda     = g_fwd[0].sel;
  assign fwdb     = g_fwd[1].sel;
  assign luse     = |ld_hit;
  assign mstall   = id_mdu_use & mdu_busy;
  assign stall    = luse | mstall;
  assign wpcir    = ~stall;
  assign bubble   = stall;
  assign flush_if = id_br_taken & wpcir;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    m_wreg_d  = e_wreg_q;
    m_m2reg_d = e_m2reg_q;
    m_rn_d    = e_rn_q;
    e_wreg_d  = 1'b0;
    e_m2reg_d = 1'b0;
    e_rn_d    = '0;
    if (wpcir) begin
      e_wreg_d  = id_wreg;
      e_m2reg_d = id_m2reg;
      e_rn_d    = id_rn;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_wreg_q    <= 1'b0;
      e_m2reg_q   <= 1'b0;
      e_rn_q      <= '0;
      m_wreg_q    <= 1'b0;
      m_m2reg_q   <= 1'b0;
      m_rn_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_wreg_q    <= e_wreg_d;
      e_m2reg_q   <= e_m2reg_d;
      e_rn_q      <= e_rn_d;
      m_wreg_q    <= m_wreg_d;
      m_m2reg_q   <= m_m2reg_d;
      m_rn_q      <= m_rn_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  mdu_seq #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu_seq (
    .clk      (clk),
    .clrn     (clrn),
    .launch   (id_mdu_op & ~stall),
    .mdu_start(mdu_start),
    .mdu_busy (mdu_busy)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MDU_LAT=4, 3-bit stall counter).
module tb_pipe_hazard_ctrl;

  localparam int RAW   = 5;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;

  logic             clk;
  logic             clrn;
  logic [RAW-1:0]   id_rs, id_rt, id_rn;
  logic             id_use_rs, id_use_rt, id_wreg, id_m2reg;
  logic             id_mdu_op, id_mdu_use, id_br_taken;
  logic [1:0]       fwda, fwdb;
  logic             wpcir, bubble, flush_if, mdu_start, mdu_busy;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  pipe_hazard_ctrl #(
    .MDU_LAT(4),
    .RAW    (RAW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_rn      (id_rn),
    .id_wreg    (id_wreg),
    .id_m2reg   (id_m2reg),
    .id_mdu_op  (id_mdu_op),
    .id_mdu_use (id_mdu_use),
    .id_br_taken(id_br_taken),
    .fwda       (fwda),
    .fwdb       (fwdb),
    .wpcir      (wpcir),
    .bubble     (bubble),
    .flush_if   (flush_if),
    .mdu_start  (mdu_start),
    .mdu_busy   (mdu_busy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  function automatic logic [31:0] observe(input string t);
    if (t == "fwda")      return {30'b0, fwda};
    if (t == "fwdb")      return {30'b0, fwdb};
    if (t == "wpcir")     return {31'b0, wpcir};
    if (t == "bubble")    return {31'b0, bubble};
    if (t == "flush_if")  return {31'b0, flush_if};
    if (t == "mdu_start") return {31'b0, mdu_start};
    if (t == "mdu_busy")  return {31'b0, mdu_busy};
    if (t == "stall_cnt") return {29'b0, stall_cnt};
    return 32'hxxxx_xxxx;
  endfunction

  task automatic drain();
    string       t;
    logic [31:0] e;
    logic [31:0] o;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      o = observe(t);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h (t=%0t)", t, o, e, $time);
      end
    end
  endtask

  task automatic setid(input logic [RAW-1:0] rs, input logic [RAW-1:0] rt,
                       input logic urs, input logic urt, input logic [RAW-1:0] rn,
                       input logic wreg, input logic m2reg, input logic mop,
                       input logic muse, input logic br);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_rn = rn;
    id_wreg = wreg; id_m2reg = m2reg; id_mdu_op = mop; id_mdu_use = muse;
    id_br_taken = br;
  endtask

  // One pipeline cycle: queue expectations, sample at the falling edge, advance.
  task automatic step(input string name, input logic [1:0] fa, input logic [1:0] fb,
                      input logic wp, input logic fl, input logic st, input logic bz);
    push("fwda", {30'b0, fa});
    push("fwdb", {30'b0, fb});
    push("wpcir", {31'b0, wp});
    push("bubble", {31'b0, ~wp});
    push("flush_if", {31'b0, fl});
    push("mdu_start", {31'b0, st});
    push("mdu_busy", {31'b0, bz});
    push("stall_cnt", 32'(exp_cnt));
    @(negedge clk);
    drain();
    $display("step %-10s fwda=%b fwdb=%b wpcir=%b flush=%b start=%b busy=%b cnt=%0d",
             name, fwda, fwdb, wpcir, flush_if, mdu_start, mdu_busy, stall_cnt);
    if (!wp && exp_cnt < CMAX) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step("reset", 2'b00, 2'b00, 1, 0, 0, 0);
    clrn = 1'b1;

    // Load-use on $2, then MEM load forwarding
    setid(0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    step("lw2", 2'b00, 2'b00, 1, 0, 0, 0);
    setid(2, 5, 1, 1, 4, 1, 0, 0, 0, 0);
    step("luse", 2'b00, 2'b00, 0, 0, 0, 0);
    step("fwd_mmem", 2'b11, 2'b00, 1, 0, 0, 0);

    // EXE ALU forward, then EXE over MEM priority, then MEM ALU
    setid(4, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    step("fwd_ealu", 2'b01, 2'b00, 1, 0, 0, 0);
    setid(0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    step("wr3", 2'b00, 2'b00, 1, 0, 0, 0);
    setid(4, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    step("prio_e", 2'b00, 2'b01, 1, 0, 0, 0);
    setid(0, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    step("fwd_malu", 2'b00, 2'b10, 1, 0, 0, 0);

    // Register $0 never forwards or stalls
    setid(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step("ld0", 2'b00, 2'b00, 1, 0, 0, 0);
    setid(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    step("r0_eld", 2'b00, 2'b00, 1, 0, 0, 0);
    setid(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step("r0_m", 2'b00, 2'b00, 1, 0, 0, 0);

    // Taken branch held by a load-use stall
    setid(0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    step("lw7", 2'b00, 2'b00, 1, 0, 0, 0);
    setid(7, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step("br_stall", 2'b00, 2'b00, 0, 0, 0, 0);
    step("br_go", 2'b11, 2'b00, 1, 1, 0, 0);
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle", 2'b00, 2'b00, 1, 0, 0, 0);

    // MDU launch, mfhi at t+2 stalls through t+4
    setid(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("mdu_t", 2'b00, 2'b00, 1, 0, 1, 0);
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mdu_t1", 2'b00, 2'b00, 1, 0, 0, 1);
    setid(0, 0, 0, 0, 8, 1, 0, 0, 1, 0);
    step("mfhi_t2", 2'b00, 2'b00, 0, 0, 0, 1);
    step("mfhi_t3", 2'b00, 2'b00, 0, 0, 0, 1);
    step("mfhi_t4", 2'b00, 2'b00, 0, 0, 0, 1);
    step("mfhi_t5", 2'b00, 2'b00, 1, 0, 0, 0);

    // Back-to-back op with mfhi waiting the full latency: counter saturates
    setid(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("mdu_u", 2'b00, 2'b00, 1, 0, 1, 0);
    setid(0, 0, 0, 0, 8, 1, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step("sat", 2'b00, 2'b00, 0, 0, 0, 1);
    step("sat_rel", 2'b00, 2'b00, 1, 0, 0, 0);

    // Reset in the middle of an MDU operation
    setid(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("mdu_v", 2'b00, 2'b00, 1, 0, 1, 0);
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mdu_v1", 2'b00, 2'b00, 1, 0, 0, 1);
    #1;
    clrn = 1'b0;
    #1;
    exp_cnt = 0;
    push("mdu_busy", 32'd0);
    push("stall_cnt", 32'd0);
    push("mdu_start", 32'd0);
    push("wpcir", 32'd1);
    drain();
    $display("async_rst busy=%b cnt=%0d", mdu_busy, stall_cnt);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    for (int i = 0; i < 6; i++) step("post_rst", 2'b00, 2'b00, 1, 0, 0, 0);
    setid(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("relaunch", 2'b00, 2'b00, 1, 0, 1, 0);
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("relaunch1", 2'b00, 2'b00, 1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined CPU (IF/ID/EXE/MEM/WB).
- Keeps its own registered scoreboard of the destination registers in EXE and MEM.
- From that scoreboard it drives the ID-stage forwarding selects (fwda/fwdb), the PC/IR write enable (wpcir) and bubble insertion.
- Also sequences the multi-cycle multiply/divide unit (MDU) and flushes IF on taken branches/jumps.

Parameters:
- MDU_LAT, 32, cycles the MDU needs per operation (>=1).
- RAW, 5, register-address width.
- CNT_W, 32, width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- id_rs  in  RAW  ID source register A.
- id_rt  in  RAW  ID source register B.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rn  in  RAW  ID destination register.
- id_wreg  in  1  ID instruction writes the regfile.
- id_m2reg  in  1  ID instruction is a load.
- id_mdu_op  in  1  ID instruction is mult/div.
- id_mdu_use  in  1  ID instruction reads HI/LO or is mult/div.
- id_br_taken  in  1  branch/jump resolved taken in ID.
- fwda  out  2  operand A source: 00 regfile, 01 EXE alu, 10 MEM alu, 11 MEM load data.
- fwdb  out  2  operand B source, same encoding.
- wpcir  out  1  1 = PC and IF/ID register update; 0 = hold.
- bubble  out  1  1 = ID/EXE register loads a NOP.
- flush_if  out  1  1 = IF/ID register loads a NOP.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_busy  out  1  MDU operation in flight.
- stall_cnt  out  CNT_W  saturating count of cycles with wpcir=0.

Behaviour:
- Reset (clrn=0, asynchronous):
  - Scoreboard EXE/MEM entries invalid (wreg=0, m2reg=0, rn=0).
  - MDU FSM in IDLE, down-counter 0, stall_cnt 0.
  - Outputs: fwda=fwdb=00, wpcir=1, bubble=0, flush_if=0, mdu_start=0, mdu_busy=0.
  - Reset mid-MDU-operation aborts it; no mdu_start is emitted after release until a new id_mdu_op arrives.
- Scoreboard: registered entries e_{wreg,m2reg,rn} and m_{wreg,m2reg,rn}. Each cycle:
  - M <= E.
  - E <= ID fields if wpcir=1, else E <= invalid (bubble).
  - Entries with rn=0 never match.
- Forwarding (combinational, per operand, X = rs or rt):
  - Priority 1: e_wreg & !e_m2reg & e_rn==X -> 01.
  - Priority 2: else m_wreg & m_rn==X -> 10 if !m_m2reg, 11 if m_m2reg.
  - Otherwise 00.
  - fwda/fwdb are driven even if the operand is unused.
- Load-use stall: luse = e_wreg & e_m2reg & e_rn!=0 & ((id_use_rs & e_rn==id_rs) | (id_use_rt & e_rn==id_rt)).
- MDU stall: mstall = id_mdu_use & mdu_busy.
- Stall: stall = luse | mstall; wpcir = !stall; bubble = stall.
- MDU FSM:
  - IDLE -> BUSY when id_mdu_op & !stall. mdu_start=1 that cycle. Counter loads MDU_LAT-1.
  - BUSY: counter decrements each cycle. mdu_busy=1.
  - BUSY -> IDLE the cycle after the counter reads 0.
  - With MDU_LAT=1, mdu_busy is high for exactly one cycle.
- Branch flush:
  - flush_if = id_br_taken & wpcir.
  - A taken branch held by a stall flushes only in the cycle it actually advances.
- Simultaneous events: luse and mstall together give a single stall. Bubble and flush can never coincide because flush requires wpcir=1.
- stall_cnt: increments on each cycle with wpcir=0; saturates at all-ones.
- Latency: forwarding, stall and flush outputs are same-cycle combinational from ID inputs and registered state. Scoreboard and FSM update on the next rising edge.

Decomposition:
- Shared package cpu_pkg:
  - fwd_sel_t encoding: FWD_RF=00, FWD_EALU=01, FWD_MALU=10, FWD_MMEM=11.
  - mdu_state_t: IDLE, BUSY.
  - RAW constant.
- One natural sub-module: mdu_seq (FSM, down-counter, mdu_start/mdu_busy), instantiated by pipe_hazard_ctrl.

Test Plan:
- Load-use: lw $2 in EXE (e_wreg=1, e_m2reg=1, rn=2); ID add reads rs=2 -> wpcir=0, bubble=1 for 1 cycle; next cycle fwda=11, wpcir=1.
- ALU forwarding priority: EXE writes $3 (alu) and MEM writes $3 (alu); ID reads rt=3 -> fwdb=01. After EXE retires with no new EXE writer -> fwdb=10.
- Register $0: EXE and MEM entries with rn=0, wreg=1; ID reads rs=0, rt=0 -> fwda=fwdb=00, no stall.
- MDU, MDU_LAT=4:
  - id_mdu_op at cycle t -> mdu_start=1 at t; mdu_busy high t+1..t+4.
  - mfhi in ID at t+2 -> wpcir=0 through t+4, released at t+5.
  - stall_cnt increases by 3.
- Branch under stall: id_br_taken=1 while luse=1 -> flush_if=0. Next cycle (stall cleared) -> flush_if=1, wpcir=1.
- Reset mid-op: clrn=0 at MDU count 2 -> mdu_busy=0, stall_cnt=0 immediately (asynchronously). After release, no mdu_start without a new id_mdu_op.
